// File: rtl/oam_scanner.sv
// Mode-2 OAM search: walks all 40 OAM entries once per scanline and collects
// up to MAX_SPRITES sprites whose vertical span covers the latched line.
module oam_scanner #(
  parameter logic [15:0] OAM_BASE    = 16'hFE00,
  parameter int          MAX_SPRITES = 10
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        tclk_in,
  input  logic        start_in,
  input  logic [7:0]  LY_in,
  input  logic        tall_sprite_mode_in,
  output logic [15:0] oam_addr_out,
  output logic        oam_req_out,
  input  logic [7:0]  oam_data_in,
  input  logic        oam_valid_in,
  output logic [17:0] sprite_buffer_out [MAX_SPRITES-1:0],
  output logic [3:0]  sprite_count_out,
  output logic        busy_out,
  output logic        done_out
);

  localparam logic [6:0] LAST_TICK = 7'd80;
  localparam logic [3:0] MAX_CNT   = 4'(MAX_SPRITES);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t      state, state_nxt;
  logic [6:0]  t, t_nxt;
  logic        clear, capture, evaluate, finish;
  logic        req_nxt;
  logic [15:0] addr_nxt;
  logic [7:0]  ly_q;
  logic        tall_q;
  logic [7:0]  y_p1;
  logic [7:0]  data_eff;
  logic [5:0]  ent_n;
  logic        hit;
  logic [17:0] entry;

  function automatic logic sprite_hit(input logic [7:0] ly, input logic [7:0] y,
                                      input logic tall);
    logic [8:0] ly16, y9, h;
    ly16 = {1'b0, ly} + 9'd16;
    y9   = {1'b0, y};
    h    = tall ? 9'd16 : 9'd8;
    return (ly16 >= y9) && (ly16 < y9 + h);
  endfunction

  function automatic logic [3:0] sprite_row(input logic [7:0] ly, input logic [7:0] y);
    logic [8:0] d;
    d = {1'b0, ly} + 9'd16 - {1'b0, y};
    return d[3:0];
  endfunction

  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    clear     = 1'b0;
    capture   = 1'b0;
    evaluate  = 1'b0;
    finish    = 1'b0;
    if (tclk_in) begin
      if (start_in) begin
        state_nxt = SCAN;
        t_nxt     = 7'd0;
        clear     = 1'b1;
      end else if (state == SCAN) begin
        capture  = t[0];
        evaluate = !t[0] && (t != 7'd0);
        if (t == LAST_TICK) begin
          state_nxt = IDLE;
          t_nxt     = 7'd0;
          finish    = 1'b1;
        end else begin
          t_nxt = t + 7'd1;
        end
      end
    end
  end

  // Even ticks fetch the Y byte, odd ticks the X byte of entry t/2.
  assign req_nxt  = (state_nxt == SCAN) && (t_nxt < LAST_TICK);
  assign addr_nxt = req_nxt ? (OAM_BASE + {8'd0, t_nxt[6:1], 2'b00} + {15'd0, t_nxt[0]})
                            : 16'h0000;

  // Stage p0: byte returned for the previous tick's request.
  assign data_eff = oam_valid_in ? oam_data_in : 8'hFF;
  assign ent_n    = t[6:1] - 6'd1;
  assign hit      = evaluate && sprite_hit(ly_q, y_p1, tall_q) && (sprite_count_out < MAX_CNT);
  assign entry    = {data_eff, ent_n, sprite_row(ly_q, y_p1)};

  // Stage p1: scan context and captured Y byte.
  always_ff @(posedge clk_in) begin
    if (clear) begin
      ly_q   <= LY_in;
      tall_q <= tall_sprite_mode_in;
    end
    if (capture) y_p1 <= data_eff;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state            <= IDLE;
      t                <= 7'd0;
      oam_req_out      <= 1'b0;
      oam_addr_out     <= 16'h0000;
      busy_out         <= 1'b0;
      done_out         <= 1'b0;
      sprite_count_out <= 4'd0;
      for (int i = 0; i < MAX_SPRITES; i++) sprite_buffer_out[i] <= 18'h0;
    end else if (tclk_in) begin
      state        <= state_nxt;
      t            <= t_nxt;
      oam_req_out  <= req_nxt;
      oam_addr_out <= addr_nxt;
      busy_out     <= (state_nxt == SCAN);
      done_out     <= finish;
      if (clear) begin
        sprite_count_out <= 4'd0;
        for (int i = 0; i < MAX_SPRITES; i++) sprite_buffer_out[i] <= 18'h0;
      end else if (hit) begin
        for (int i = 0; i < MAX_SPRITES; i++)
          if (sprite_count_out == 4'(i)) sprite_buffer_out[i] <= entry;
        sprite_count_out <= sprite_count_out + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_oam_scanner.sv
// Scoreboard bench for oam_scanner: a behavioural model predicts each scan's
// sprite buffer, which is checked when done_out fires.
module tb_oam_scanner;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        tclk_in;
  logic        start_in;
  logic [7:0]  LY_in;
  logic        tall_sprite_mode_in;
  logic [15:0] oam_addr_out;
  logic        oam_req_out;
  logic [7:0]  oam_data_in;
  logic        oam_valid_in;
  logic [17:0] sprite_buffer_out [9:0];
  logic [3:0]  sprite_count_out;
  logic        busy_out;
  logic        done_out;

  oam_scanner dut (
    .clk_in(clk_in), .rst_in(rst_in), .tclk_in(tclk_in), .start_in(start_in),
    .LY_in(LY_in), .tall_sprite_mode_in(tall_sprite_mode_in),
    .oam_addr_out(oam_addr_out), .oam_req_out(oam_req_out),
    .oam_data_in(oam_data_in), .oam_valid_in(oam_valid_in),
    .sprite_buffer_out(sprite_buffer_out), .sprite_count_out(sprite_count_out),
    .busy_out(busy_out), .done_out(done_out)
  );

  typedef struct packed {
    logic [3:0]       cnt;
    logic [9:0][17:0] slot;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] oam_y [40];
  logic [7:0] oam_x [40];
  bit         valid_en = 1'b1;
  int         gdiv = 1;
  int         gphase = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 clk_in = ~clk_in;

  // T-cycle enable: one in every gdiv clocks, changed just after the edge.
  initial begin
    tclk_in = 1'b1;
    forever begin
      @(posedge clk_in);
      #2;
      gphase  = (gphase + 1) % gdiv;
      tclk_in = (gphase == 0);
    end
  end

  // OAM memory: data for a request appears in the following T-cycle.
  initial begin
    oam_data_in  = 8'h00;
    oam_valid_in = 1'b0;
    forever begin
      int idx;
      @(posedge clk_in);
      if (tclk_in) begin
        idx = int'(oam_addr_out) - 32'hFE00;
        if (oam_req_out && idx >= 0 && idx < 160) begin
          oam_data_in  <= idx[0] ? oam_x[idx >> 2] : oam_y[idx >> 2];
          oam_valid_in <= valid_en;
        end else begin
          oam_data_in  <= 8'h00;
          oam_valid_in <= 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic [7:0] ly, input bit tall, input bit vld);
    exp_t e;
    int ly16, y, x, h, c;
    e = '0;
    c = 0;
    ly16 = int'(ly) + 16;
    h = tall ? 16 : 8;
    for (int n = 0; n < 40; n++) begin
      y = vld ? int'(oam_y[n]) : 255;
      x = vld ? int'(oam_x[n]) : 255;
      if (ly16 >= y && ly16 < y + h && c < 10) begin
        e.slot[c] = {x[7:0], n[5:0], 4'(ly16 - y)};
        c++;
      end
    end
    e.cnt = 4'(c);
    return e;
  endfunction

  task automatic clear_oam();
    for (int n = 0; n < 40; n++) begin
      oam_y[n] = 8'h00;
      oam_x[n] = 8'h00;
    end
  endtask

  task automatic layout_single();
    clear_oam();
    oam_y[0] = 8'd16;
    oam_x[0] = 8'd8;
  endtask

  task automatic layout_overflow();
    clear_oam();
    for (int n = 3; n <= 14; n++) begin
      oam_y[n] = 8'd60;
      oam_x[n] = 8'(n + 1);
    end
  endtask

  task automatic layout_height();
    clear_oam();
    oam_y[5] = 8'd16;
    oam_x[5] = 8'h55;
  endtask

  task automatic start_scan(input logic [7:0] ly, input logic tall);
    @(negedge clk_in);
    while (!tclk_in) @(negedge clk_in);
    LY_in               = ly;
    tall_sprite_mode_in = tall;
    start_in            = 1'b1;
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
  endtask

  // Called 1 time unit after the start edge.
  task automatic wait_done(input int gd);
    int   tc;
    bit   seen;
    bit   te;
    exp_t e;
    tc = 0;
    seen = 1'b0;
    check("busy_start", busy_out, 1);
    check("addr_t0", oam_addr_out, 32'hFE00);
    check("req_t0", oam_req_out, 1);
    for (int c = 0; c < 90 * gd; c++) begin
      @(posedge clk_in);
      te = tclk_in;
      if (te) tc++;
      #1;
      if (done_out) begin
        seen = 1'b1;
        break;
      end
      if (te && tc < 80) begin
        check($sformatf("addr_t%0d", tc), oam_addr_out, 32'hFE00 + (tc / 2) * 4 + (tc % 2));
      end else if (te && tc == 80) begin
        check("req_t80", oam_req_out, 0);
        check("busy_t80", busy_out, 1);
      end
    end
    check("done_seen", seen, 1);
    check("done_latency", tc, 81);
    check("busy_at_done", busy_out, 0);
    check("sb_nonempty", exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("count", sprite_count_out, e.cnt);
      for (int i = 0; i < 10; i++)
        check($sformatf("slot%0d", i), sprite_buffer_out[i], e.slot[i]);
    end
    te = 1'b0;
    for (int c = 0; c < gd + 2 && !te; c++) begin
      @(posedge clk_in);
      te = tclk_in;
      #1;
    end
    check("done_one_tcycle", done_out, 0);
  endtask

  task automatic run_scan(input logic [7:0] ly, input bit tall);
    exp_q.push_back(model(ly, tall, valid_en));
    start_scan(ly, tall);
    wait_done(gdiv);
  endtask

  task automatic wait_tedges(input int n, output bit saw_done);
    int tc;
    tc = 0;
    saw_done = 1'b0;
    for (int c = 0; c < 10 * n && tc < n; c++) begin
      @(posedge clk_in);
      if (tclk_in) tc++;
      #1;
      if (done_out) saw_done = 1'b1;
    end
  endtask

  initial begin
    bit saw;
    rst_in              = 1'b1;
    start_in            = 1'b0;
    LY_in               = 8'd0;
    tall_sprite_mode_in = 1'b0;
    clear_oam();
    #1;
    check("rst_busy", busy_out, 0);
    check("rst_done", done_out, 0);
    check("rst_req", oam_req_out, 0);
    check("rst_addr", oam_addr_out, 0);
    check("rst_count", sprite_count_out, 0);
    check("rst_slot0", sprite_buffer_out[0], 0);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;

    layout_single();
    run_scan(8'd0, 1'b0);
    layout_overflow();
    run_scan(8'd50, 1'b0);
    layout_height();
    run_scan(8'd15, 1'b0);
    run_scan(8'd15, 1'b1);
    run_scan(8'd7, 1'b0);
    run_scan(8'd16, 1'b1);

    layout_single();
    valid_en = 1'b0;
    run_scan(8'd0, 1'b0);
    valid_en = 1'b1;

    // Asynchronous reset in the middle of a scan.
    layout_single();
    start_scan(8'd0, 1'b0);
    wait_tedges(30, saw);
    check("abort_pre_slot0", sprite_buffer_out[0], 18'h02000);
    rst_in = 1'b1;
    #1;
    check("abort_busy", busy_out, 0);
    check("abort_req", oam_req_out, 0);
    check("abort_addr", oam_addr_out, 0);
    check("abort_count", sprite_count_out, 0);
    check("abort_slot0", sprite_buffer_out[0], 0);
    check("abort_done", done_out, 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    wait_tedges(100, saw);
    check("abort_no_done", saw, 0);

    // Restart at tick 40: only the second pass may show up.
    layout_overflow();
    oam_y[0] = 8'd16;
    oam_x[0] = 8'd8;
    exp_q.push_back(model(8'd0, 1'b0, 1'b1));
    start_scan(8'd50, 1'b0);
    wait_tedges(40, saw);
    check("restart_no_early_done", saw, 0);
    start_scan(8'd0, 1'b0);
    wait_done(1);

    gdiv = 4;
    layout_single();
    run_scan(8'd0, 1'b0);
    layout_overflow();
    run_scan(8'd50, 1'b0);
    gdiv = 1;

    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
